// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and helpers for the Nios II OCI DCT capture engine.
package nios2_oci_dct_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } dct_state_e;

    // Limits a reported lane count to the number of lanes physically present.
    function automatic int unsigned clamp_lanes(input int unsigned count, input int unsigned lanes);
        return (count > lanes) ? lanes : count;
    endfunction

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// Synchronous FIFO for packed DCT entries: registered level, full/empty flags,
// no write-to-read pass-through, synchronous clear for abort.
module nios2_oci_dct_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_reg == LVL_W'(DEPTH));
    assign empty    = (level_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];
    assign level    = level_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// DCT capture engine: buffers packed multi-lane words and serialises them lane
// by lane. Optional per-word capture timestamp under DCT_CAPTURE_TS_EN.
module nios2_oci_dct_capture
    import nios2_oci_dct_pkg::*;
#(
    parameter int LANE_W = 10,
    parameter int LANES  = 3,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16,
    parameter int TS_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dct_valid,
    input  logic [LANES*LANE_W-1:0]    dct_buffer,
    input  logic [CNT_W-1:0]           dct_count,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [LANE_W-1:0]          rd_data,
    output logic                       rd_last,
    output logic [TS_W-1:0]            rd_ts,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       done
);

    localparam int BUF_W = LANES * LANE_W;
    localparam int CW    = $clog2(LANES + 1);

`ifdef DCT_CAPTURE_TS_EN
    typedef struct packed {
        logic [CW-1:0]    count;
        logic [BUF_W-1:0] buffer;
        logic [TS_W-1:0]  ts;
    } entry_t;
`else
    typedef struct packed {
        logic [CW-1:0]    count;
        logic [BUF_W-1:0] buffer;
    } entry_t;
`endif

    localparam int ENTRY_W = $bits(entry_t);

    dct_state_e        state_reg, state_next;
    entry_t            push_entry, pop_entry, word_reg;
    logic              out_valid_reg;
    logic [CW-1:0]     lane_reg;
    logic [DROP_W-1:0] drop_reg;
    logic              fifo_full, fifo_empty;
    logic              push_req, push_en, drop_en, pop_en;
    logic              handshake, on_last, unpacker_free;
    logic [LANE_W-1:0] lane_data [LANES];

`ifdef DCT_CAPTURE_TS_EN
    logic [TS_W-1:0] ts_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
        end
    end
`endif

    always_comb begin
        push_entry        = '0;
        push_entry.count  = CW'(clamp_lanes(32'(dct_count), LANES));
        push_entry.buffer = dct_buffer;
`ifdef DCT_CAPTURE_TS_EN
        push_entry.ts     = ts_reg;
`endif
    end

    // A push blocked by flush/abort/done is not an overflow, so it never counts as a drop.
    assign push_req      = dct_valid && (dct_count != '0) && (state_reg == ST_RUN)
                           && !test_ending && !test_has_ended;
    assign push_en       = push_req && !fifo_full;
    assign drop_en       = push_req && fifo_full;
    assign handshake     = out_valid_reg && rd_ready;
    assign on_last       = (lane_reg == word_reg.count - CW'(1));
    assign unpacker_free = !out_valid_reg || (handshake && on_last);
    assign pop_en        = unpacker_free && !fifo_empty && (state_reg != ST_DONE) && !test_has_ended;

    nios2_oci_dct_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (test_has_ended),
        .push      (push_en),
        .push_data (push_entry),
        .pop       (pop_en),
        .pop_data  (pop_entry),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        if (test_has_ended) begin
            state_next = ST_DONE;
        end else begin
            case (state_reg)
                ST_RUN:   if (test_ending) state_next = ST_FLUSH;
                ST_FLUSH: if (fifo_empty && unpacker_free) state_next = ST_DONE;
                default:  state_next = ST_DONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            lane_reg      <= '0;
            word_reg      <= '0;
        end else if (test_has_ended) begin
            out_valid_reg <= 1'b0;
            lane_reg      <= '0;
            word_reg      <= '0;
        end else if (pop_en) begin
            out_valid_reg <= 1'b1;
            lane_reg      <= '0;
            word_reg      <= pop_entry;
        end else if (handshake) begin
            if (on_last) begin
                out_valid_reg <= 1'b0;
            end else begin
                lane_reg <= lane_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_reg <= '0;
        end else if (drop_en && (drop_reg != '1)) begin
            drop_reg <= drop_reg + DROP_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_data[gi] = word_reg.buffer[gi*LANE_W +: LANE_W];
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_reg == CW'(i)) begin
                rd_data = lane_data[i];
            end
        end
    end

    assign rd_valid   = out_valid_reg;
    assign rd_last    = out_valid_reg && on_last;
    assign drop_count = drop_reg;
    assign done       = (state_reg == ST_DONE);

`ifdef DCT_CAPTURE_TS_EN
    assign rd_ts = word_reg.ts;
`else
    assign rd_ts = '0;
`endif

endmodule
